// File: rtl/wave_seq_if.sv
// wave_seq_if: CPU memory bus between a bus master and the wave_seq playlist
// sequencer.
//   mem_valid  master -> slave  request strobe, held until mem_ready
//   mem_ready  slave -> master  one-cycle acknowledge
//   mem_addr   master -> slave  byte address
//   mem_wdata  master -> slave  write data
//   mem_wstrb  master -> slave  byte strobes (zero = read)
//   mem_rdata  slave -> master  read data, valid while mem_ready is high
interface wave_seq_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/wave_seq.sv
// wave_seq: plays a table of waveform-generator settings. Each entry pushes
// MODE, P1 and P2 into the generator, then holds for DUR cycles, and the
// sequencer steps to the next entry, loops, or switches the generator off.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   bus          CPU register bus (slave side)
//   gen_addr_o   generator register select {28'b0, sel, 2'b00}
//   gen_wdata_o  generator register write data
//   gen_we_o     one-cycle generator write strobe
module wave_seq #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  wave_seq_if.slave   bus,
  output logic [31:0] gen_addr_o,
  output logic [31:0] gen_wdata_o,
  output logic        gen_we_o
);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [2:0] LAST_MAX = 3'(ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MODE, S_WR_P1, S_WR_P2, S_HOLD, S_WR_OFF
  } state_t;

  // byte-lane merge of a write into the current register contents
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        loop_q;
  logic [2:0]  last_q;
  logic        start_pend_q, start_pend_d;
  logic        abort_pend_q, abort_pend_d;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] gen_addr_q, gen_addr_d;
  logic [31:0] gen_wdata_q, gen_wdata_d;
  logic        gen_we_q, gen_we_d;

  logic [2:0]  mode_q [ENTRIES];
  logic [31:0] p1_q   [ENTRIES];
  logic [31:0] p2_q   [ENTRIES];
  logic [31:0] dur_q  [ENTRIES];

  logic          acc_s, wr_s, busy_s;
  logic          is_ctrl_s, is_stat_s, is_abort_s, is_tab_s;
  logic [3:0]    ent_s;
  logic [IW-1:0] ent_idx_s, gen_idx_s;
  logic [1:0]    fld_s;
  logic [31:0]   rd_val_s, wr_val_s;
  logic [2:0]    last_in_s;
  logic          unused_s;

  // Requests are taken when mem_valid is seen with mem_ready low; commands
  // take effect one cycle later, i.e. the cycle after mem_ready.
  assign acc_s      = bus.mem_valid && !ready_q;
  assign wr_s       = acc_s && (bus.mem_wstrb != 4'b0000);
  assign busy_s     = (state_q != S_IDLE);
  assign is_ctrl_s  = (bus.mem_addr[7:2] == 6'd0);
  assign is_stat_s  = (bus.mem_addr[7:2] == 6'd1);
  assign is_abort_s = (bus.mem_addr[7:2] == 6'd2);
  assign ent_s      = bus.mem_addr[7:4] - 4'd4;
  assign is_tab_s   = (bus.mem_addr[7:6] != 2'b00) && (ent_s < 4'(ENTRIES));
  assign ent_idx_s  = ent_s[IW-1:0];
  assign fld_s      = bus.mem_addr[3:2];
  assign wr_val_s   = merge_bytes(rd_val_s, bus.mem_wdata, bus.mem_wstrb);
  assign last_in_s  = (wr_val_s[6:4] >= LAST_MAX) ? LAST_MAX : wr_val_s[6:4];
  assign unused_s   = ^{bus.mem_addr[31:8], bus.mem_addr[1:0]};

  // register read mux (also the base for byte-masked writes)
  always_comb begin
    rd_val_s = 32'h0;
    if (is_ctrl_s) begin
      rd_val_s = {25'h0, last_q, 2'b00, loop_q, 1'b0};
    end else if (is_stat_s) begin
      rd_val_s = {23'h0, done_q, 1'b0, idx_q, 3'b000, busy_s};
    end else if (is_tab_s) begin
      case (fld_s)
        2'd0:    rd_val_s = {29'h0, mode_q[ent_idx_s]};
        2'd1:    rd_val_s = p1_q[ent_idx_s];
        2'd2:    rd_val_s = p2_q[ent_idx_s];
        default: rd_val_s = dur_q[ent_idx_s];
      endcase
    end else begin
      rd_val_s = 32'h0;
    end
  end

  // bus response and command capture
  always_comb begin
    rdata_d      = (acc_s && !wr_s) ? rd_val_s : 32'h0;
    start_pend_d = wr_s && is_ctrl_s && wr_val_s[0];
    abort_pend_d = wr_s && is_abort_s;
  end

  // CTRL and playlist table storage; table is frozen while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_q <= 1'b0;
      last_q <= 3'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        mode_q[i] <= 3'd0;
        p1_q[i]   <= 32'h0;
        p2_q[i]   <= 32'h0;
        dur_q[i]  <= 32'h0;
      end
    end else if (wr_s && is_ctrl_s) begin
      loop_q <= wr_val_s[1];
      last_q <= last_in_s;
    end else if (wr_s && is_tab_s && !busy_s) begin
      case (fld_s)
        2'd0:    mode_q[ent_idx_s] <= wr_val_s[2:0];
        2'd1:    p1_q[ent_idx_s]   <= wr_val_s;
        2'd2:    p2_q[ent_idx_s]   <= wr_val_s;
        default: dur_q[ent_idx_s]  <= wr_val_s;
      endcase
    end
  end

  // sequencer next state; a pending ABORT outranks any entry boundary
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    if (abort_pend_q && busy_s) begin
      state_d   = S_WR_OFF;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pend_q) begin
            state_d   = S_WR_MODE;
            idx_d     = 3'd0;
            done_d    = 1'b0;
            aborted_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WR_MODE: state_d = S_WR_P1;
        S_WR_P1:   state_d = S_WR_P2;
        S_WR_P2: begin
          state_d = S_HOLD;
          cnt_d   = (dur_q[idx_q[IW-1:0]] == 32'h0) ? 32'd1 : dur_q[idx_q[IW-1:0]];
        end
        S_HOLD: begin
          if (cnt_q > 32'd1) begin
            cnt_d = cnt_q - 32'd1;
          end else if (idx_q < last_q) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_WR_MODE;
          end else if (loop_q) begin
            idx_d   = 3'd0;
            state_d = S_WR_MODE;
          end else begin
            state_d = S_WR_OFF;
          end
        end
        S_WR_OFF: begin
          state_d = S_IDLE;
          done_d  = !aborted_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // generator outputs precomputed from the next state so they are registered
  assign gen_idx_s = idx_d[IW-1:0];
  always_comb begin
    gen_addr_d  = 32'h0000_000C;
    gen_wdata_d = 32'h0;
    gen_we_d    = 1'b0;
    case (state_d)
      S_WR_MODE: begin
        gen_addr_d  = 32'h0000_0000;
        gen_wdata_d = {29'h0, mode_q[gen_idx_s]};
        gen_we_d    = 1'b1;
      end
      S_WR_P1: begin
        gen_addr_d  = 32'h0000_0004;
        gen_wdata_d = p1_q[gen_idx_s];
        gen_we_d    = 1'b1;
      end
      S_WR_P2: begin
        gen_addr_d  = 32'h0000_0008;
        gen_wdata_d = p2_q[gen_idx_s];
        gen_we_d    = 1'b1;
      end
      S_WR_OFF: begin
        gen_addr_d  = 32'h0000_0000;
        gen_wdata_d = 32'h0;
        gen_we_d    = 1'b1;
      end
      default: begin
        gen_addr_d  = 32'h0000_000C;
        gen_wdata_d = 32'h0;
        gen_we_d    = 1'b0;
      end
    endcase
  end

  // sequencer, bus and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 32'h0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      start_pend_q <= 1'b0;
      abort_pend_q <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= 32'h0;
      gen_addr_q   <= 32'h0000_000C;
      gen_wdata_q  <= 32'h0;
      gen_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      start_pend_q <= start_pend_d;
      abort_pend_q <= abort_pend_d;
      ready_q      <= acc_s;
      rdata_q      <= rdata_d;
      gen_addr_q   <= gen_addr_d;
      gen_wdata_q  <= gen_wdata_d;
      gen_we_q     <= gen_we_d;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign gen_addr_o    = gen_addr_q;
  assign gen_wdata_o   = gen_wdata_q;
  assign gen_we_o      = gen_we_q;
endmodule

// File: doc/wave_seq.md
WAVE_SEQ -- requirements
Module: wave_seq

Interface
REQ-001 Parameter: ENTRIES, 8, playlist depth; SHALL be a power of two, 2..8.
REQ-002 clk  input  1  system clock; all state SHALL change on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_valid  input  1  CPU bus request.
REQ-005 mem_ready  output  1  one-cycle bus acknowledge.
REQ-006 mem_addr  input  32  byte address; only bits [7:0] are decoded.
REQ-007 mem_wdata  input  32  write data.
REQ-008 mem_wstrb  input  4  byte strobes; nonzero means write, zero means read.
REQ-009 mem_rdata  output  32  read data, valid while mem_ready is high.
REQ-010 gen_addr  output  32  generator register select {28'b0, sel[1:0], 2'b00}.
REQ-011 gen_wdata  output  32  generator write data.
REQ-012 gen_we  output  1  one-cycle strobe marking a generator register write.

Function
REQ-013 Bus handshake: mem_ready SHALL rise the cycle after mem_valid is seen with mem_ready low, stay high one cycle, then fall; each access completes in exactly 2 cycles.
REQ-014 Register map (addr[7:0]):
- 0x00 CTRL, R/W: bit0 START (write 1 = start; reads 0), bit1 LOOP, bits[6:4] LAST (final entry index).
- 0x04 STATUS, RO: bit0 BUSY, bits[6:4] IDX (current entry), bit8 DONE (sticky).
- 0x08 ABORT, WO: any write aborts.
- 0x40+16*i: MODE[2:0]; +4 P1; +8 P2; +C DUR (i < ENTRIES).
- Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-015 Table writes while BUSY SHALL be ignored; CTRL LOOP/LAST writes while BUSY SHALL take effect at the next entry boundary.
REQ-016 LAST values >= ENTRIES SHALL be clamped to ENTRIES-1 when written.
REQ-017 FSM states: IDLE, WR_MODE, WR_P1, WR_P2, HOLD, WR_OFF.
REQ-018 IDLE: gen_addr=0x0C (OUTP, no side effect), gen_we=0, BUSY=0. A START write SHALL clear DONE, set IDX=0 and go to WR_MODE on the cycle after mem_ready.
REQ-019 WR_MODE: gen_addr=0x00, gen_wdata={29'b0, MODE[IDX]}, gen_we=1, for 1 cycle; then WR_P1.
REQ-020 WR_P1: gen_addr=0x04, gen_wdata=P1[IDX], gen_we=1, for 1 cycle; then WR_P2.
REQ-021 WR_P2: gen_addr=0x08, gen_wdata=P2[IDX], gen_we=1, for 1 cycle; then HOLD with the duration counter loaded.
REQ-022 HOLD: gen_addr=0x0C, gen_we=0 for max(DUR[IDX],1) cycles (DUR=0 is treated as 1); 32-bit counter with no wrap.
REQ-023 At the end of HOLD:
- IDX<LAST: IDX+1, then WR_MODE.
- IDX==LAST with LOOP=1: IDX=0, then WR_MODE.
- Otherwise: WR_OFF.
REQ-024 Entry period SHALL be exactly 3+max(DUR,1) cycles, with no gap cycles between entries.
REQ-025 WR_OFF: gen_addr=0x00, gen_wdata=0 (mode OFF), gen_we=1, for 1 cycle; then IDLE, setting DONE=1 only if WR_OFF was entered by normal completion.
REQ-026 ABORT write while BUSY: FSM SHALL go to WR_OFF on the cycle after mem_ready, from any state; DONE SHALL stay 0. ABORT while IDLE SHALL be ignored.
REQ-027 START while BUSY SHALL be ignored. Simultaneous START and ABORT cannot occur (single bus); an ABORT in the same cycle as an internal entry boundary SHALL win.
REQ-028 BUSY SHALL be 1 in every state except IDLE, including WR_OFF.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, mem_ready=0, mem_rdata=0, gen_addr=0x0C, gen_wdata=0, gen_we=0, CTRL=0, DONE=0, IDX=0, and all table entries to 0.
REQ-030 Reset mid-sequence SHALL NOT issue a WR_OFF write; the generator is reset separately.

Verification
REQ-031 Entry0 {MODE=2, P1=5, P2=3, DUR=4}, LAST=0, START -> gen_we pulses at 0x00/2, 0x04/5, 0x08/3 on consecutive cycles; 4 HOLD cycles; 0x00/0 write; STATUS=0x100.
REQ-032 Entries 0..2 with DUR=1,2,0 and LOOP=1 -> IDX sequence 0,1,2,0; periods of 4,5,4 cycles; BUSY stays 1.
REQ-033 ABORT during HOLD of entry 1 (DUR=100) -> WR_OFF 2 cycles after the ABORT request; BUSY=0 next cycle; DONE=0.
REQ-034 While BUSY, write P1 of entry 0 and issue START -> both ignored; readback of P1 returns the old value.
REQ-035 Assert rst during WR_P1 -> outputs at reset values within the same cycle; no further gen_we pulses; STATUS reads 0.
REQ-036 Write CTRL LAST=7 with ENTRIES=4 -> CTRL readback shows LAST=3; read of 0x10 returns 0.
